// File: rtl/spi_port_slave.sv
// Half-duplex SPI-style port: host writes land in a small RX FIFO, core words are
// driven back once the host grants the bus. Bus turnaround handled by a 4-state FSM.
//
// state | meaning
// IDLE  | bus quiet, waiting for host write or core transmit request
// WR    | host is writing, words pushed into RX FIFO
// TURN  | asking host to turn the bus toward this block
// RD    | this block drives the bus while granted
module spi_port_slave #(
    parameter int DATA_W   = 128,
    parameter int RX_DEPTH = 4,
    parameter int NF_TH    = RX_DEPTH - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I_spi_cs_n,
    input  logic              I_OE_req,
    input  logic [DATA_W-1:0] I_spi_data,
    output logic [DATA_W-1:0] O_spi_data,
    output logic              O_spi_data_oe,
    output logic              O_config_req,
    output logic              O_near_full,
    output logic              O_switch_rdwr,
    output logic              O_overflow,
    input  logic              I_cfg_need,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_MSB = {1'b1, {AW{1'b0}}};
    localparam logic [PW-1:0] NF_LVL  = PW'(NF_TH);

    typedef enum logic [1:0] {IDLE, WR, TURN, RD} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [RX_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, occ;
    logic              empty, full, pop, host_word, push, drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!I_spi_cs_n && !I_OE_req)  state_nxt = WR;
                else if (tx_valid && I_spi_cs_n) state_nxt = TURN;
            end
            WR:      if (I_spi_cs_n) state_nxt = IDLE;
            TURN:    if (I_OE_req && !I_spi_cs_n) state_nxt = RD;
            RD:      if (I_spi_cs_n || !I_OE_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The IDLE->WR cycle already carries the first host word, so it is captured too.
    assign host_word = !I_spi_cs_n && ((state == IDLE && !I_OE_req) || state == WR);

    assign occ   = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = ((wr_ptr ^ rd_ptr) == PTR_MSB);
    assign pop   = !empty && rx_ready;
    assign push  = host_word && (!full || pop);
    assign drop  = host_word && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= I_spi_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            O_overflow   <= 1'b0;
            O_near_full  <= 1'b0;
            O_config_req <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop) O_overflow <= 1'b1;
            O_near_full  <= (occ >= NF_LVL);
            O_config_req <= I_cfg_need && empty && (state == IDLE);
        end
    end

    assign rx_valid = !empty;
    assign rx_data  = mem[rd_ptr[AW-1:0]];

    // Output enable is purely combinational so an async reset releases the pad at once.
    assign O_spi_data_oe = (state == RD) && I_OE_req && !I_spi_cs_n;
    assign O_spi_data    = (O_spi_data_oe && tx_valid) ? tx_data : '0;
    assign O_switch_rdwr = (state == TURN) || (state == RD && tx_valid);
    assign tx_ready      = O_spi_data_oe;

endmodule

// File: tb/tb_spi_port_slave.sv
// Bench for spi_port_slave: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_spi_port_slave;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int NF    = 3;

    localparam int M_IDLE = 0;
    localparam int M_WR   = 1;
    localparam int M_TURN = 2;
    localparam int M_RD   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cs_n, oe_req, cfg_need, rx_ready, tx_valid;
    logic [DW-1:0] spi_in, tx_data;
    logic [DW-1:0] spi_out, rx_data;
    logic          spi_oe, config_req, near_full, switch_rdwr, overflow, rx_valid, tx_ready;

    always #5 clk = ~clk;

    spi_port_slave #(.DATA_W(DW), .RX_DEPTH(DEPTH), .NF_TH(NF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .I_spi_cs_n   (cs_n),
        .I_OE_req     (oe_req),
        .I_spi_data   (spi_in),
        .O_spi_data   (spi_out),
        .O_spi_data_oe(spi_oe),
        .O_config_req (config_req),
        .O_near_full  (near_full),
        .O_switch_rdwr(switch_rdwr),
        .O_overflow   (overflow),
        .I_cfg_need   (cfg_need),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    int total = 0;
    int bad   = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode number, FIFO as a queue, registered flags.
    int            m_mode;
    logic [DW-1:0] m_q[$];
    logic          m_ovf, m_nf, m_cfg;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_q.delete();
        m_ovf = 1'b0;
        m_nf  = 1'b0;
        m_cfg = 1'b0;
    endtask

    task automatic model_step();
        bit pop, host, was_full;
        pop      = (m_q.size() != 0) && rx_ready;
        host     = !cs_n && ((m_mode == M_IDLE && !oe_req) || m_mode == M_WR);
        was_full = (m_q.size() == DEPTH);
        m_cfg    = cfg_need && (m_q.size() == 0) && (m_mode == M_IDLE);
        m_nf     = (m_q.size() >= NF);
        if (pop) void'(m_q.pop_front());
        if (host) begin
            if (!was_full || pop) m_q.push_back(spi_in);
            else                  m_ovf = 1'b1;
        end
        case (m_mode)
            M_IDLE: if (!cs_n && !oe_req) m_mode = M_WR;
                    else if (tx_valid && cs_n) m_mode = M_TURN;
            M_WR:   if (cs_n) m_mode = M_IDLE;
            M_TURN: if (oe_req && !cs_n) m_mode = M_RD;
            default: if (cs_n || !oe_req) m_mode = M_IDLE;
        endcase
    endtask

    task automatic check_model();
        logic e_oe;
        e_oe = (m_mode == M_RD) && oe_req && !cs_n;
        check1("oe", spi_oe, e_oe);
        check1("tx_ready", tx_ready, e_oe);
        checkw("spi_out", spi_out, (e_oe && tx_valid) ? tx_data : '0);
        check1("switch", switch_rdwr, (m_mode == M_TURN) || (m_mode == M_RD && tx_valid));
        check1("rx_valid", rx_valid, m_q.size() != 0);
        if (m_q.size() != 0) checkw("rx_data", rx_data, m_q[0]);
        check1("near_full", near_full, m_nf);
        check1("overflow", overflow, m_ovf);
        check1("config_req", config_req, m_cfg);
    endtask

    task automatic drive(input logic cs, input logic oe, input logic tv, input logic [DW-1:0] td,
                         input logic [DW-1:0] d, input logic rr, input logic cn);
        cs_n = cs; oe_req = oe; tx_valid = tv; tx_data = td;
        spi_in = d; rx_ready = rr; cfg_need = cn;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_reset_outputs();
        check1("rst_oe", spi_oe, 1'b0);
        check1("rst_switch", switch_rdwr, 1'b0);
        check1("rst_rx_valid", rx_valid, 1'b0);
        check1("rst_tx_ready", tx_ready, 1'b0);
        check1("rst_overflow", overflow, 1'b0);
        check1("rst_near_full", near_full, 1'b0);
        check1("rst_config_req", config_req, 1'b0);
        checkw("rst_spi_out", spi_out, '0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs();
        release_reset();
    endtask

    typedef struct {
        logic          cs;
        logic          rr;
        logic [DW-1:0] d;
        logic          rv;
        logic [DW-1:0] rd;
        logic          nf;
        logic          ovf;
    } vec_t;

    function automatic vec_t mk(bit cs, bit rr, int d, bit rv, int rd, bit nf, bit ovf);
        vec_t v;
        v.cs = cs; v.rr = rr; v.d = DW'(d); v.rv = rv; v.rd = DW'(rd); v.nf = nf; v.ovf = ovf;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        // write burst of six words into a 4-deep FIFO, then drain
        tbl[0]  = mk(0, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 2, 1, 1, 0, 0);
        tbl[2]  = mk(0, 0, 3, 1, 1, 0, 0);
        tbl[3]  = mk(0, 0, 4, 1, 1, 0, 0);
        tbl[4]  = mk(0, 0, 5, 1, 1, 1, 0);
        tbl[5]  = mk(0, 0, 6, 1, 1, 1, 1);
        tbl[6]  = mk(1, 0, 0, 1, 1, 1, 1);
        tbl[7]  = mk(1, 1, 0, 1, 1, 1, 1);
        tbl[8]  = mk(1, 1, 0, 1, 2, 1, 1);
        tbl[9]  = mk(1, 1, 0, 1, 3, 1, 1);
        tbl[10] = mk(1, 1, 0, 1, 4, 0, 1);
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 1);

        #2;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].cs, 1'b0, 1'b0, '0, tbl[i].d, tbl[i].rr, 1'b0);
            #3;
            check1($sformatf("tbl%0d_rx_valid", i), rx_valid, tbl[i].rv);
            if (tbl[i].rv) checkw($sformatf("tbl%0d_rx_data", i), rx_data, tbl[i].rd);
            check1($sformatf("tbl%0d_near_full", i), near_full, tbl[i].nf);
            check1($sformatf("tbl%0d_overflow", i), overflow, tbl[i].ovf);
            check1($sformatf("tbl%0d_switch", i), switch_rdwr, 1'b0);
            tick();
        end

        // host write wins over a pending transmit request
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h55, 32'h9, 1'b0, 1'b0);
        #3 check1("prio_switch_idle", switch_rdwr, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h55, 32'h0, 1'b0, 1'b0);
        #3;
        check1("prio_switch_wr", switch_rdwr, 1'b0);
        check1("prio_rx_valid", rx_valid, 1'b1);
        checkw("prio_rx_data", rx_data, 32'h9);
        tick();

        // config request follows empty+IDLE with one cycle of latency
        do_reset();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        #3 check1("cfg_c0", config_req, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, 32'h3, 1'b0, 1'b1);
        #3 check1("cfg_c1", config_req, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        #3 tick();
        #3 check1("cfg_after_wr", config_req, 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        #3 check1("cfg_nonempty", config_req, 1'b0);
        tick();
        #3 check1("cfg_drained", config_req, 1'b1);
        tick();

        // read turnaround, then asynchronous reset in the middle of RD
        do_reset();
        drive(1'b0, 1'b0, 1'b0, '0, 32'h7, 1'b0, 1'b0);
        #3 tick();
        drive(1'b1, 1'b0, 1'b1, 32'hA5, '0, 1'b0, 1'b0);
        #3 check1("rd_switch_wr", switch_rdwr, 1'b0);
        tick();
        #3 check1("rd_switch_idle", switch_rdwr, 1'b0);
        tick();
        #3;
        check1("rd_switch_turn", switch_rdwr, 1'b1);
        check1("rd_oe_turn", spi_oe, 1'b0);
        checkw("rd_out_turn", spi_out, '0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'hA5, '0, 1'b0, 1'b0);
        #3 check1("rd_oe_turn_grant", spi_oe, 1'b0);
        tick();
        #3;
        check1("rd_oe", spi_oe, 1'b1);
        checkw("rd_out", spi_out, 32'hA5);
        check1("rd_tx_ready", tx_ready, 1'b1);
        check1("rd_switch", switch_rdwr, 1'b1);
        check1("rd_rx_valid", rx_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check1("midrd_oe", spi_oe, 1'b0);
        check1("midrd_switch", switch_rdwr, 1'b0);
        check1("midrd_rx_valid", rx_valid, 1'b0);
        checkw("midrd_out", spi_out, '0);
        model_reset();
        release_reset();

        // randomized traffic against the reference model
        for (int blk = 0; blk < 3; blk++) begin
            do_reset();
            for (int c = 0; c < 600; c++) begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      DW'($urandom), DW'($urandom), ($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)));
                #3 check_model();
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
